aer_readout_scheduler: RTL
==========================

# aer_readout_scheduler

Readout scheduler above the top-level pixel arbiter tree. Gates the arbiter enable, captures each granted pixel address with a timestamp into a small event FIFO, and emits address-event words to the downstream link over a valid/ready handshake. Stops arbitration when the FIFO nears full, so grants are not lost to link backpressure. Counts completed arbitration groups.

## Interface

**Parameters**
- ADD_W, 2, width of the row address and of the column address from the arbiter.
- TS_W, 16, timestamp counter width.
- DEPTH, 4, event FIFO depth. Power of 2, at least 4.
- GCNT_W, 8, width of the group counter.

**Ports**
- clk_i, input, 1: clock.
- reset_i, input, 1: reset, asynchronous, active-high.
- run_i, input, 1: global readout enable. When 0, the block is forced to IDLE.
- arb_req_i, input, 1: any request pending in the arbiter tree (arbiter req_o).
- arb_active_i, input, 1: a pixel grant is valid this cycle (arbiter active_o).
- arb_x_add_i, input, ADD_W: granted row address.
- arb_y_add_i, input, ADD_W: granted column address.
- arb_grp_release_i, input, 1: arbiter has served all active requests of the current group.
- arb_enable_o, output, 1: enable to the arbiter tree.
- evt_valid_o, output, 1: an event word is available.
- evt_ready_i, input, 1: downstream accepts the word.
- evt_data_o, output, TS_W+2*ADD_W: event word {timestamp, x, y}.
- grp_cnt_o, output, GCNT_W: count of completed groups; wraps.
- ovf_o, output, 1: sticky flag, set when an event was dropped.
- state_o, output, 2: current FSM state, for debug.

## Operation

- **Timestamp counter.** ts increments every cycle, wraps from 2^TS_W-1 to 0, and runs in every state.
- **FSM states:** IDLE=00, ARB=01, STALL=10.
  - IDLE: arb_enable_o=0. Go to ARB when run_i=1 and arb_req_i=1.
  - ARB: arb_enable_o=1.
    - Go to IDLE when run_i=0.
    - Otherwise go to IDLE when arb_grp_release_i=1 and arb_req_i=0.
    - Otherwise go to STALL when the next-cycle FIFO count is at least DEPTH-1.
  - STALL: arb_enable_o=0.
    - Go to IDLE when run_i=0.
    - Go to ARB when FIFO count is at most DEPTH-2 and arb_req_i=1.
    - Go to IDLE when FIFO count is at most DEPTH-2 and arb_req_i=0.
- arb_enable_o is a registered output decoded from the next state, so it changes on the same edge as the state.
- **Capture.**
  - On any edge where arb_active_i=1, push {ts, arb_x_add_i, arb_y_add_i}. This applies in any state, because a grant can still land in the cycle after the enable drops.
  - If the FIFO is full and no pop happens on the same edge, the word is dropped and ovf_o is set.
- **Pop.** On any edge where evt_valid_o=1 and evt_ready_i=1.
- **Simultaneous push and pop.**
  - Count is unchanged, and both operations take effect.
  - This applies at full too: the push is accepted, not dropped.
- **Group counter.** grp_cnt_o increments on each cycle in which arb_grp_release_i=1 while state is ARB. It wraps.
- **Clearing.** ovf_o clears only on reset. When run_i=0, the FIFO is not flushed; it keeps draining.

## Timing

- **Reset values:** arb_enable_o=0, evt_valid_o=0, evt_data_o=0, grp_cnt_o=0, ovf_o=0, state_o=IDLE, ts=0, FIFO empty.
- **Enable latency.** arb_req_i rises with run_i=1 at edge N; arb_enable_o=1 after edge N, i.e. 1 cycle.
- **Event latency.** A capture at edge N gives evt_valid_o=1 after edge N when the FIFO was empty. evt_data_o is driven from the head entry.
- **Output hold.** evt_data_o and evt_valid_o stay stable while evt_valid_o=1 and evt_ready_i=0.
- **Drain rate.** Back-to-back pops give one word per cycle.
- **Stall margin.**
  - Arbitration stops with one free slot left, which absorbs the single in-flight grant.
  - Under correct operation, ovf_o never sets unless the arbiter asserts arb_active_i for 2 or more cycles after the enable drops.
- **Timestamp wrap.** The ts value stored is the value before the edge increment.
- **Reset mid-operation.** The FIFO contents are discarded, and arb_enable_o drops asynchronously.

## Test plan

1. **Single event.**
   - Stimulus: reset, run_i=1, arb_req_i=1, one cycle of arb_active_i with x=2 and y=3 at ts=5, evt_ready_i=1.
   - Required: arb_enable_o=1 one cycle after the request; evt_valid_o=1 for one cycle with evt_data_o={5,2,3}.
2. **Backpressure.**
   - Stimulus: evt_ready_i=0, DEPTH=4, arb_active_i every cycle.
   - Required: state goes to STALL and arb_enable_o drops after the 3rd push; the 4th in-flight push is accepted; ovf_o stays 0; after releasing ready, the 4 words come out in order and state returns to ARB.
3. **Forced overflow.**
   - Stimulus: FIFO full, evt_ready_i=0, one extra arb_active_i.
   - Required: ovf_o=1 and stays 1 afterwards; FIFO count stays 4; the dropped word never appears on the output.
4. **Group completion.**
   - Stimulus: in ARB, arb_grp_release_i=1 with arb_req_i=0.
   - Required: grp_cnt_o increments by 1, state goes to IDLE, arb_enable_o=0. Repeated 256 times, grp_cnt_o wraps to 0.
5. **Simultaneous push and pop at full.**
   - Stimulus: count=4, arb_active_i=1 and evt_ready_i=1 on the same edge.
   - Required: count stays 4, ovf_o stays 0, the new word is appended last.
6. **Run and reset.**
   - Stimulus: drop run_i mid-ARB, then assert reset_i asynchronously between edges.
   - Required: IDLE on the next edge; queued words continue to drain; reset gives all outputs their reset values immediately.

Source files
------------

// File: rtl/aer_readout_scheduler.sv
// aer_readout_scheduler
// Sits above the top-level pixel arbiter tree. It gates the arbiter enable and
// stamps each granted pixel address with a free-running timestamp. The stamped
// words go into a small event FIFO and leave over a valid/ready link.
// Arbitration pauses while the FIFO is nearly full, so the last in-flight grant
// still has a free slot. The block also counts completed arbitration groups.
//
// Ports
//   clk_i, reset_i         clock, asynchronous active-high reset
//   run_i                  global readout enable (0 forces IDLE)
//   arb_req_i              a request is pending somewhere in the arbiter tree
//   arb_active_i           a pixel grant is valid this cycle
//   arb_x_add_i/arb_y_add_i granted row / column address
//   arb_grp_release_i      arbiter finished the current group
//   arb_enable_o           enable to the arbiter tree
//   evt_valid_o/evt_ready_i/evt_data_o  event link, data = {ts, x, y}
//   grp_cnt_o              wrapping count of completed groups
//   ovf_o                  sticky: an event was dropped
//   state_o                FSM state (IDLE=00, ARB=01, STALL=10)
module aer_readout_scheduler #(
    parameter int unsigned ADD_W  = 2,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned GCNT_W = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      run_i,
    input  logic                      arb_req_i,
    input  logic                      arb_active_i,
    input  logic [ADD_W-1:0]          arb_x_add_i,
    input  logic [ADD_W-1:0]          arb_y_add_i,
    input  logic                      arb_grp_release_i,
    output logic                      arb_enable_o,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [TS_W+2*ADD_W-1:0]   evt_data_o,
    output logic [GCNT_W-1:0]         grp_cnt_o,
    output logic                      ovf_o,
    output logic [1:0]                state_o
);

    localparam int unsigned DATA_W = TS_W + 2 * ADD_W;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HIGH_CNT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LOW_CNT  = CNT_W'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARB   = 2'b01,
        S_STALL = 2'b10
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                enable_next;
    logic                grp_inc;

    logic [TS_W-1:0]     ts;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    rd_ptr_next;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic [DATA_W-1:0]   push_word;
    logic [DATA_W-1:0]   head_next;
    logic                pop;
    logic                push_ok;
    logic                drop;

    // Free-running timestamp, runs in every state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // FIFO control. A pop on the same edge frees a slot, so a push at full is
    // accepted in that case.
    always_comb begin
        push_word   = {ts, arb_x_add_i, arb_y_add_i};
        pop         = evt_valid_o & evt_ready_i;
        push_ok     = arb_active_i & ((count != FULL_CNT) | pop);
        drop        = arb_active_i & (count == FULL_CNT) & ~pop;
        rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next  = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
        // The next head may be the word being written on this edge (FIFO empty
        // after the pop), which is not in mem yet.
        if (push_ok && (wr_ptr == rd_ptr_next)) begin
            head_next = push_word;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // Event storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers, occupancy and registered head/valid outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            evt_valid_o <= 1'b0;
            evt_data_o  <= '0;
            ovf_o       <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            evt_valid_o <= (count_next != '0);
            evt_data_o  <= head_next;
            if (drop) begin
                ovf_o <= 1'b1;
            end
        end
    end

    // FSM state register; the enable is decoded from the next state so it
    // changes on the same edge as the state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= S_IDLE;
            arb_enable_o <= 1'b0;
        end else begin
            state        <= state_next;
            arb_enable_o <= enable_next;
        end
    end

    // FSM next-state logic. ARB looks at the post-edge count so the stall
    // leaves one free slot for the grant already in flight.
    always_comb begin
        state_next = state;
        if (!run_i) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_req_i) begin
                        state_next = S_ARB;
                    end
                end
                S_ARB: begin
                    if (arb_grp_release_i && !arb_req_i) begin
                        state_next = S_IDLE;
                    end else if (count_next >= HIGH_CNT) begin
                        state_next = S_STALL;
                    end
                end
                S_STALL: begin
                    if (count <= LOW_CNT) begin
                        state_next = arb_req_i ? S_ARB : S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        enable_next = 1'b0;
        grp_inc     = 1'b0;
        if (state_next == S_ARB) begin
            enable_next = 1'b1;
        end
        if ((state == S_ARB) && arb_grp_release_i) begin
            grp_inc = 1'b1;
        end
    end

    // Completed-group counter, wraps naturally.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grp_cnt_o <= '0;
        end else if (grp_inc) begin
            grp_cnt_o <= grp_cnt_o + GCNT_W'(1);
        end
    end

    assign state_o = state;

endmodule
